code_decoder_3to8_seq: RTL and testbench
========================================

// Module: code_decoder_3to8_seq
// PURPOSE
//  Sequential 3-to-8 decoder, the receive-side counterpart of the 8-to-3 encoder.
//  Accepts a stream of 3-bit codes over a valid/ready handshake.
//  Drives the matching one-hot line of d_out[7:0] for HOLD_CYCLES clocks, then all-zero for GAP_CYCLES clocks.
//  Sits between a code source (e.g. an encoder link or a command FIFO) and one-hot select or strobe consumers.
// PARAMETERS
//  HOLD_CYCLES  4   clocks each one-hot line stays asserted; legal range >=1
//  GAP_CYCLES   1   all-zero clocks forced between consecutive codes; legal range >=0
//  CNT_W        16  width of the decoded-code counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_code is valid
//  in_ready   out  1      block can accept a code this cycle
//  in_code    in   3      binary code 0..7
//  abort      in   1      synchronous flush (see BEHAVIOUR)
//  d_out      out  8      registered one-hot output; bit k set for code k
//  done       out  1      one-cycle pulse when a code's drive window ends
//  busy       out  1      (state != IDLE) || buf_valid
//  dec_count  out  CNT_W  number of codes fully driven; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - d_out=0, done=0, dec_count=0, buf_valid=0, state=IDLE.
//   - in_ready=0 while reset is asserted; in_ready=1 from the first clock after deassertion.
//   - Reset mid-drive discards the active code and the buffered code; no done pulse.
//  Handshake:
//   - A transfer occurs on a clock edge with in_valid && in_ready.
//   - in_ready = !buf_valid && !abort (combinational on abort only).
//  One-entry buffer:
//   - An accepted code goes straight to DRIVE when the FSM is free (see the FSM table below).
//   - Otherwise it is stored in buf_code and buf_valid is set.
//   - The buffer is popped only on the cycle the FSM loads a new code.
//   - Push and pop cannot coincide because in_ready=0 while full.
//  FSM states: IDLE, DRIVE, GAP. A down-counter cnt is sized $clog2(max(HOLD,GAP)+1).
//   IDLE:
//    - On an accepted code: d_out <= 1<<code, cnt <= HOLD_CYCLES-1, go to DRIVE.
//    - Latency: a code accepted at edge N shows on d_out after edge N (i.e. in cycle N+1).
//   DRIVE:
//    - d_out is held; cnt decrements.
//    - At cnt==0: d_out <= 0, done <= 1 for one cycle, dec_count <= dec_count+1.
//    - Then: if GAP_CYCLES>0 go to GAP (cnt <= GAP_CYCLES-1); else take the "load next" path.
//   GAP:
//    - d_out=0; cnt decrements.
//    - At cnt==0 take the "load next" path.
//   Load next:
//    - Priority: buf_valid (load buf_code, clear buf_valid) > accepted input this cycle (load in_code).
//    - Load target: the next state is DRIVE with d_out <= one-hot of the loaded code.
//    - Otherwise go to IDLE.
//    - With GAP_CYCLES=0, back-to-back codes produce contiguous one-hot windows with no zero cycle.
//    - Even with GAP_CYCLES=0, done still pulses between the windows.
//  Timing invariant: d_out is at most one-hot in every cycle; it changes only on window boundaries.
//  abort=1 at an edge:
//   - state <= IDLE, d_out <= 0, buf_valid <= 0.
//   - No done pulse; dec_count unchanged.
//   - abort takes priority over every other event, including a simultaneous accept, which is dropped.
// STRUCTURE
//  Shared package: state enum {IDLE, DRIVE, GAP} and the function onehot8(code) -> 8'b1<<code.
//  Single module; no sub-module needed (buffer + FSM + counters fit inline).
//  Elaboration check: HOLD_CYCLES>=1 and GAP_CYCLES>=0, else $fatal.
// TESTING
//  1. Reset release, then code 3 sent once.
//     -> d_out=8'h08 for exactly 4 cycles starting 1 cycle after accept.
//     -> Then 1 zero cycle; done pulses once; dec_count=1.
//  2. All codes 0..7 streamed with in_valid held high.
//     -> d_out sequence 01,02,..,80, each held 4 cycles with a 1-cycle zero gap.
//     -> in_ready drops while the buffer is full; dec_count=8.
//  3. GAP_CYCLES=0, HOLD_CYCLES=1, codes 5 then 6 back-to-back.
//     -> d_out=8'h20 then 8'h40 on consecutive cycles; two done pulses.
//  4. Code 7 accepted, abort at the 2nd drive cycle with code 2 buffered.
//     -> d_out=0 next cycle; buffer empty; no done; dec_count unchanged.
//     -> Next code accepted normally.
//  5. rst_n asserted asynchronously mid-DRIVE.
//     -> d_out=0 immediately, without waiting for a clock edge; all outputs at their reset values.
//  6. CNT_W=4, 17 codes driven -> dec_count wraps to 1; one-hot property checked every cycle.

Source files
------------

// File: rtl/code_decoder_3to8_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : code_decoder_3to8_seq_pkg
// Description : Shared types and helpers for the sequential 3-to-8 decoder.
//               - state_e  : FSM encoding (IDLE / DRIVE / GAP)
//               - onehot8  : 3-bit binary code -> 8-bit one-hot line
// Revision    : 1.0 - initial release
// ============================================================================
package code_decoder_3to8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    onehot8 = 8'b0000_0001 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_decoder_3to8_seq.sv
`default_nettype none
// ============================================================================
// Module      : code_decoder_3to8_seq
// Description : Sequential 3-to-8 decoder. Accepts 3-bit codes over a
//               valid/ready handshake, drives the matching one-hot line of
//               d_out for HOLD_CYCLES clocks, then forces GAP_CYCLES all-zero
//               clocks before the next code. A one-entry buffer lets the
//               source hand over the next code while the current one drives.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - in_code is valid
//               in_ready   - block can accept a code this cycle
//               in_code    - binary code 0..7
//               abort      - synchronous flush of FSM and buffer
//               d_out      - registered one-hot output (bit k for code k)
//               done       - one-cycle pulse when a drive window ends
//               busy       - FSM not idle or buffer occupied
//               dec_count  - codes fully driven, wraps modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module code_decoder_3to8_seq
  import code_decoder_3to8_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic             abort,
  output logic [7:0]       d_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] dec_count
);

  localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_load  =
      (GAP_CYCLES > 0) ? c_cnt_w'(GAP_CYCLES - 1) : '0;

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 0) begin : g_param_check
    $fatal(1, "code_decoder_3to8_seq: HOLD_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end

  state_e             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [7:0]         d_out_q, d_out_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   dec_count_q, dec_count_d;
  logic               buf_valid_q, buf_valid_d;
  logic [2:0]         buf_code_q, buf_code_d;
  // Holds in_ready low until the first clock edge after reset release.
  logic               ready_en_q;

  logic w_accept;
  logic w_load_next;
  logic w_park;

  assign in_ready = ready_en_q && !buf_valid_q && !abort;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_out_d     = d_out_q;
    done_d      = 1'b0;
    dec_count_d = dec_count_q;
    buf_valid_d = buf_valid_q;
    buf_code_d  = buf_code_q;
    w_load_next = 1'b0;
    w_park      = 1'b0;

    if (abort) begin
      // Flush everything; a simultaneous accept cannot happen since
      // in_ready is forced low by abort.
      state_d     = IDLE;
      cnt_d       = '0;
      d_out_d     = '0;
      buf_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_d = DRIVE;
            d_out_d = onehot8(in_code);
            cnt_d   = c_hold_load;
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            d_out_d     = '0;
            done_d      = 1'b1;
            dec_count_d = dec_count_q + 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = c_gap_load;
              w_park  = w_accept;
            end else begin
              w_load_next = 1'b1;
            end
          end else begin
            cnt_d  = cnt_q - 1'b1;
            w_park = w_accept;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            w_load_next = 1'b1;
          end else begin
            cnt_d  = cnt_q - 1'b1;
            w_park = w_accept;
          end
        end
        default: begin
          state_d = IDLE;
          d_out_d = '0;
        end
      endcase

      // End of a window (or gap): buffered code wins over a fresh accept.
      if (w_load_next) begin
        if (buf_valid_q) begin
          state_d     = DRIVE;
          d_out_d     = onehot8(buf_code_q);
          cnt_d       = c_hold_load;
          buf_valid_d = 1'b0;
        end else if (w_accept) begin
          state_d = DRIVE;
          d_out_d = onehot8(in_code);
          cnt_d   = c_hold_load;
        end else begin
          state_d = IDLE;
          d_out_d = '0;
        end
      end

      // Code accepted while the FSM is occupied waits in the buffer.
      if (w_park) begin
        buf_valid_d = 1'b1;
        buf_code_d  = in_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_out_q     <= '0;
      done_q      <= 1'b0;
      dec_count_q <= '0;
      buf_valid_q <= 1'b0;
      buf_code_q  <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_out_q     <= d_out_d;
      done_q      <= done_d;
      dec_count_q <= dec_count_d;
      buf_valid_q <= buf_valid_d;
      buf_code_q  <= buf_code_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign d_out     = d_out_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE) || buf_valid_q;
  assign dec_count = dec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_code_decoder_3to8_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_decoder_3to8_seq
// Description : Scoreboard bench for code_decoder_3to8_seq. Three instances:
//               A = HOLD 4 / GAP 1 / CNT_W 16, B = HOLD 1 / GAP 0,
//               C = HOLD 4 / GAP 1 / CNT_W 4. Stimulus pushes expected
//               windows; a negedge monitor pops them as windows appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_decoder_3to8_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_n, in_valid, in_ready, abort, done, busy;
  logic [2:0][2:0] in_code;
  logic [2:0][7:0] d_out;
  logic [15:0]     dc_a, dc_b;
  logic [3:0]      dc_c;

  code_decoder_3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .abort(abort[0]), .d_out(d_out[0]), .done(done[0]),
    .busy(busy[0]), .dec_count(dc_a));

  code_decoder_3to8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .abort(abort[1]), .d_out(d_out[1]), .done(done[1]),
    .busy(busy[1]), .dec_count(dc_b));

  code_decoder_3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_code(in_code[2]), .abort(abort[2]), .d_out(d_out[2]), .done(done[2]),
    .busy(busy[2]), .dec_count(dc_c));

  // Hand-written one-hot table, indexed by code.
  localparam logic [7:0] c_oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                      8'h10, 8'h20, 8'h40, 8'h80};

  // len == 0 marks a window that is cut short by reset: its length and
  // done pulse are not checked.
  typedef struct {
    logic [7:0] val;
    int         len;
    bit         done_exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       run_mon = 1'b0;
  int         sel = 0;
  int         last_sel = 0;
  logic [7:0] prev_v = '0;
  logic [7:0] cur_v;
  int         run = 0;
  exp_t       cur_exp = '{8'h00, 0, 1'b0};
  int         starts[$];
  int         done_cnt [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (run_mon) begin
      if (sel != last_sel) begin
        prev_v   = '0;
        run      = 0;
        last_sel = sel;
      end
      cur_v = d_out[sel];
      chk("onehot", 32'($countones(cur_v) <= 1), 32'd1);
      if (prev_v != 8'h00 && cur_v != prev_v && cur_exp.len != 0) begin
        chk("hold_len", run, cur_exp.len);
        chk("done_at_end", 32'(done[sel]), 32'(cur_exp.done_exp));
      end
      if (cur_v != 8'h00 && cur_v != prev_v) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_window: got 0x%0h, expected none", cur_v);
          cur_exp.len = 0;
        end else begin
          cur_exp = exp_q.pop_front();
          chk("window_val", cur_v, cur_exp.val);
          starts.push_back(cyc);
        end
        run = 1;
      end else if (cur_v != 8'h00) begin
        run++;
      end
      prev_v = cur_v;
      if (done[sel]) done_cnt[sel]++;
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic send(input int id, input logic [2:0] code, input logic [7:0] val,
                      input int len, input bit dexp, input bit push,
                      output int stalls);
    bit acc;
    int n;
    acc    = 1'b0;
    n      = 0;
    stalls = 0;
    in_valid[id] = 1'b1;
    in_code[id]  = code;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready[id];
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: dut %0d code %0d not accepted, expected accept", id, code);
    end else if (push) begin
      exp_q.push_back('{val, len, dexp});
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[id] || d_out[id] != 8'h00) && n < 300);
    if (busy[id] || d_out[id] != 8'h00) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: dut %0d still busy, expected idle", id);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int st;
    int stall_tot;
    int base;
    int d0;

    rst_n    = '0;
    in_valid = '0;
    abort    = '0;
    in_code  = '0;

    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(in_ready[i]), 32'd0);
      chk("rst_dout", 32'(d_out[i]), 32'h0);
    end
    @(negedge clk);
    rst_n = '1;
    #1;
    chk("ready_before_first_clk", 32'(in_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ready_after_rst", 32'(in_ready[i]), 32'd1);
      chk("done_after_rst", 32'(done[i]), 32'd0);
      chk("busy_after_rst", 32'(busy[i]), 32'd0);
    end
    chk("dec_count_a_rst", 32'(dc_a), 32'd0);
    chk("dec_count_c_rst", 32'(dc_c), 32'd0);

    run_mon = 1'b1;
    sel     = 0;

    // in_ready follows abort combinationally
    abort[0] = 1'b1;
    #1;
    chk("ready_abort_comb", 32'(in_ready[0]), 32'd0);
    abort[0] = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: single code 3
    send(0, 3'd3, 8'h08, 4, 1'b1, 1'b1, st);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_latency", 32'(d_out[0]), 32'h08);
    wait_idle(0);
    chk("t1_dec_count", 32'(dc_a), 32'd1);
    chk("t1_done_pulses", done_cnt[0], 32'd1);

    // Test 2: stream all codes with in_valid held high
    base      = starts.size();
    stall_tot = 0;
    for (int k = 0; k < 8; k++) begin
      send(0, 3'(k), c_oh[k], 4, 1'b1, 1'b1, st);
      stall_tot += st;
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    chk("t2_ready_dropped", 32'(stall_tot > 0), 32'd1);
    chk("t2_dec_count", 32'(dc_a), 32'd9);
    chk("t2_done_pulses", done_cnt[0], 32'd9);
    chk("t2_windows", starts.size() - base, 32'd8);
    if (starts.size() - base == 8) begin
      for (int k = 1; k < 8; k++)
        chk("t2_window_spacing", starts[base+k] - starts[base+k-1], 32'd5);
    end

    // Test 4: abort during 2nd drive cycle of code 7 with code 2 buffered
    d0 = done_cnt[0];
    send(0, 3'd7, 8'h80, 2, 1'b0, 1'b1, st);
    send(0, 3'd2, 8'h04, 0, 1'b0, 1'b0, st);
    in_valid[0] = 1'b0;
    chk("t4_busy_before_abort", 32'(busy[0]), 32'd1);
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    @(negedge clk);
    chk("t4_dout_cleared", 32'(d_out[0]), 32'h0);
    chk("t4_no_done", 32'(done[0]), 32'd0);
    chk("t4_buffer_empty", 32'(busy[0]), 32'd0);
    chk("t4_ready", 32'(in_ready[0]), 32'd1);
    chk("t4_dec_count_held", 32'(dc_a), 32'd9);
    @(posedge clk);
    #1;
    send(0, 3'd4, 8'h10, 4, 1'b1, 1'b1, st);
    in_valid[0] = 1'b0;
    wait_idle(0);
    chk("t4_dec_count_after", 32'(dc_a), 32'd10);
    chk("t4_done_pulses", done_cnt[0] - d0, 32'd1);

    // Test 3: HOLD 1 / GAP 0, codes 5 then 6 back-to-back
    sel  = 1;
    base = starts.size();
    send(1, 3'd5, 8'h20, 1, 1'b1, 1'b1, st);
    send(1, 3'd6, 8'h40, 1, 1'b1, 1'b1, st);
    in_valid[1] = 1'b0;
    wait_idle(1);
    chk("t3_windows", starts.size() - base, 32'd2);
    if (starts.size() - base == 2)
      chk("t3_contiguous", starts[base+1] - starts[base], 32'd1);
    chk("t3_dec_count", 32'(dc_b), 32'd2);
    chk("t3_done_pulses", done_cnt[1], 32'd2);

    // Test 6: CNT_W 4, 17 codes -> counter wraps to 1
    sel = 2;
    for (int k = 0; k < 17; k++)
      send(2, 3'(k % 8), c_oh[k % 8], 4, 1'b1, 1'b1, st);
    in_valid[2] = 1'b0;
    wait_idle(2);
    chk("t6_dec_count_wrap", 32'(dc_c), 32'd1);
    chk("t6_done_pulses", done_cnt[2], 32'd17);

    // Test 5: asynchronous reset mid-drive
    send(2, 3'd1, 8'h02, 0, 1'b0, 1'b1, st);
    in_valid[2] = 1'b0;
    @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("t5_dout_async", 32'(d_out[2]), 32'h0);
    chk("t5_done_async", 32'(done[2]), 32'd0);
    chk("t5_busy_async", 32'(busy[2]), 32'd0);
    chk("t5_ready_async", 32'(in_ready[2]), 32'd0);
    chk("t5_count_async", 32'(dc_c), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    #1;
    chk("t5_ready_before_clk", 32'(in_ready[2]), 32'd0);
    @(posedge clk);
    #1;
    chk("t5_ready_after_clk", 32'(in_ready[2]), 32'd1);
    send(2, 3'd6, 8'h40, 4, 1'b1, 1'b1, st);
    in_valid[2] = 1'b0;
    wait_idle(2);
    chk("t5_dec_count_after", 32'(dc_c), 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
